// File: rtl/pipelined_mult_hs.sv
// Parametrised signed/unsigned multiplier pipeline with valid/ready flow
// control and a sideband tag that travels alongside each product.
module pipelined_mult_hs #(
    parameter int A_WIDTH     = 18,
    parameter int B_WIDTH     = 18,
    parameter int PIPE_STAGES = 3,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    input  logic                       sgn,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0] p,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic                       busy
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int NREG    = PIPE_STAGES + 1;

    logic                 adv;
    logic                 v0_q;
    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic                 sgn_q;
    logic [TAG_WIDTH-1:0] tag0_q;

    logic [NREG-1:0]      v_q;
    logic [P_WIDTH-1:0]   pd_q  [NREG];
    logic [TAG_WIDTH-1:0] tag_q [NREG];

    logic [P_WIDTH-1:0]   ext_a;
    logic [P_WIDTH-1:0]   ext_b;
    logic [P_WIDTH-1:0]   prod_d;

    // Extending to the full product width makes the signed case exact mod 2^P.
    always_comb begin
        ext_a  = {{(P_WIDTH-A_WIDTH){a_q[A_WIDTH-1] & sgn_q}}, a_q};
        ext_b  = {{(P_WIDTH-B_WIDTH){b_q[B_WIDTH-1] & sgn_q}}, b_q};
        prod_d = ext_a * ext_b;
    end

    assign out_valid = v_q[NREG-1];
    assign p         = pd_q[NREG-1];
    assign out_tag   = tag_q[NREG-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv & rst_n;
    assign busy      = v0_q | (|v_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            tag0_q <= '0;
            v_q    <= '0;
            for (int i = 0; i < NREG; i++) begin
                pd_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            v0_q     <= in_valid & in_ready;
            a_q      <= a;
            b_q      <= b;
            sgn_q    <= sgn;
            tag0_q   <= in_tag;
            v_q[0]   <= v0_q;
            pd_q[0]  <= prod_d;
            tag_q[0] <= tag0_q;
            for (int i = 1; i < NREG; i++) begin
                v_q[i]   <= v_q[i-1];
                pd_q[i]  <= pd_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mult_hs.sv
// Bench for pipelined_mult_hs: scoreboard on the default build plus
// directed corner cases on a narrow, shallow build.
module tb_pipelined_mult_hs;

    localparam int A   = 18;
    localparam int B   = 18;
    localparam int P   = A + B;
    localparam int T   = 4;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [A-1:0] a;
    logic [B-1:0] b;
    logic         sgn;
    logic [T-1:0] in_tag, out_tag;
    logic         out_valid, out_ready, busy;
    logic [P-1:0] p;

    logic         in_valid1, in_ready1, sgn1;
    logic [7:0]   a1;
    logic [11:0]  b1;
    logic [3:0]   in_tag1, out_tag1;
    logic         out_valid1, out_ready1, busy1;
    logic [19:0]  p1;

    int n_vec = 0;
    int n_err = 0;
    int mode  = 0;
    int advcnt = 0;

    typedef struct {
        logic [P-1:0] p;
        logic [T-1:0] tag;
        int           n;
    } exp_t;
    exp_t q[$];

    bit           prev_stall = 0;
    logic [P-1:0] prev_p;
    logic [T-1:0] prev_tag;

    always #5 clk = ~clk;

    pipelined_mult_hs u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .out_tag(out_tag), .busy(busy)
    );

    pipelined_mult_hs #(
        .A_WIDTH(8), .B_WIDTH(12), .PIPE_STAGES(1), .TAG_WIDTH(4)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sgn(sgn1), .in_tag(in_tag1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .p(p1), .out_tag(out_tag1), .busy(busy1)
    );

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] model(input logic [A-1:0] x,
                                           input logic [B-1:0] y,
                                           input bit s);
        longint sx, sy;
        logic [63:0] t;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[A-1]) sx = sx - (longint'(1) << A);
        if (s && y[B-1]) sy = sy - (longint'(1) << B);
        t = 64'(sx * sy);
        return t[P-1:0];
    endfunction

    // Scoreboard: each entry must leave after exactly LAT pipe advances.
    always @(negedge clk) begin
        if (!rst_n) begin
            check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
            q.delete();
            prev_stall = 0;
        end else begin
            check(in_ready == (out_ready | ~out_valid), "in_ready",
                  in_ready, out_ready | ~out_valid);
            check(busy == (q.size() != 0), "busy", busy, q.size() != 0);
            if (prev_stall)
                check(out_valid && p == prev_p && out_tag == prev_tag,
                      "stall_hold", {out_valid, p}, {1'b1, prev_p});
            if (q.size() != 0 && q[0].n + LAT == advcnt)
                check(out_valid, "missing_out", out_valid, 1);
            if (out_valid) begin
                check(q.size() != 0, "spurious_out", p, 0);
                if (q.size() != 0) begin
                    check(q[0].n + LAT == advcnt, "latency",
                          advcnt - q[0].n, LAT);
                    check(p == q[0].p, "product", p, q[0].p);
                    check(out_tag == q[0].tag, "tag", out_tag, q[0].tag);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back('{p: model(a, b, sgn), tag: in_tag, n: advcnt});
            prev_stall = out_valid && !out_ready;
            prev_p     = p;
            prev_tag   = out_tag;
            if (in_ready) advcnt++;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [A-1:0] ta, input logic [B-1:0] tb,
                        input bit ts, input logic [T-1:0] tt);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        sgn = ts;
        in_tag = tt;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) check(acc, "send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = out_valid;
        end
        check(ok, "wait_valid", ok, 1);
    endtask

    task automatic u1_op(input bit s, input logic [19:0] exp);
        in_valid1 = 1'b1;
        a1 = 8'h80;
        b1 = 12'h7FF;
        sgn1 = s;
        in_tag1 = 4'(s + 2);
        @(negedge clk);
        check(in_ready1, "u1_in_ready", in_ready1, 1);
        step();
        in_valid1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) begin
                check(!out_valid1, "u1_early", out_valid1, 0);
            end else begin
                check(out_valid1, "u1_valid", out_valid1, 1);
                check(p1 == exp, "u1_p", p1, exp);
                check(out_tag1 == 4'(s + 2), "u1_tag", out_tag1, s + 2);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b0;
        in_tag = '0;
        in_valid1 = 1'b0;
        a1 = '0;
        b1 = '0;
        sgn1 = 1'b0;
        in_tag1 = '0;
        out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check(!out_valid, "reset_valid", out_valid, 0);
        check(p == '0, "reset_p", p, 0);
        check(out_tag == '0, "reset_tag", out_tag, 0);
        check(!busy, "reset_busy", busy, 0);
        step();

        send(18'h3FFFF, 18'h3FFFF, 1'b0, 4'd5);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            if (i < LAT) begin
                check(!out_valid, "uns_early", out_valid, 0);
            end else begin
                check(out_valid, "uns_valid", out_valid, 1);
                check(p == 36'hFFFF80001, "uns_p", p, 36'hFFFF80001);
                check(out_tag == 4'd5, "uns_tag", out_tag, 5);
            end
        end
        step();

        send(18'h3FFFF, 18'h00002, 1'b1, 4'd1);
        send(18'h20000, 18'h20000, 1'b1, 4'd2);
        send(18'h3FFFF, 18'h3FFFF, 1'b1, 4'd3);
        wait_valid();
        check(p == 36'hFFFFFFFFE, "sgn_p0", p, 36'hFFFFFFFFE);
        @(negedge clk);
        check(out_valid && p == 36'h400000000, "sgn_p1", p, 36'h400000000);
        @(negedge clk);
        check(out_valid && p == 36'h000000001, "sgn_p2", p, 36'h1);
        step();

        mode = 1;
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 2)) step();
            send(A'($urandom), B'($urandom), 1'($urandom), T'($urandom));
        end
        mode = 0;
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        check(q.size() == 0, "bp_drain", q.size(), 0);
        step();

        mode = 2;
        step();
        step();
        for (int n = 0; n < 5; n++)
            send(A'($urandom), B'($urandom), 1'(n & 1), T'(n + 8));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(!in_ready && out_valid, "full_stall",
                  {in_ready, out_valid}, 2'b01);
        end
        mode = 0;
        for (int k = 0; k < 5 && !out_ready; k++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check(out_valid && out_ready, "drain_seq", out_valid, 1);
        end
        step();

        send(18'd11, 18'd12, 1'b0, 4'd1);
        send(18'd13, 18'd14, 1'b1, 4'd2);
        send(18'd15, 18'd16, 1'b0, 4'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check(!out_valid, "midrst_valid", out_valid, 0);
        check(p == '0, "midrst_p", p, 0);
        check(!busy, "midrst_busy", busy, 0);
        step();
        send(18'd3, 18'd7, 1'b0, 4'd9);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            if (i != LAT) begin
                check(!out_valid, "post_rst_quiet", out_valid, 0);
            end else begin
                check(out_valid && p == 36'd21, "post_rst_p", p, 21);
                check(out_tag == 4'd9, "post_rst_tag", out_tag, 9);
            end
        end
        step();

        u1_op(1'b1, 20'hC0080);
        step();
        u1_op(1'b0, 20'h3FF80);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
